// File: rtl/spi_slave_interface.sv
// spi_slave_interface: SPI mode-3 responder with oversampled pins and a byte-wide parallel side in the clk domain.
// Optional receive-overrun tracking (rx_ack / rx_overrun) is enabled by defining SPI_SLAVE_OVERRUN_DET_EN.
`default_nettype none

module spi_slave_interface #(
  parameter int CLK_FREC    = 100000000,
  parameter int SCL_FREC    = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic [7:0] byte_2_send,
  output logic       tx_latched,
  output logic [7:0] byte_received,
  output logic       rx_valid,
  input  logic       msb_lsb,
  output logic       busy,
  input  logic       scl,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe
`ifdef SPI_SLAVE_OVERRUN_DET_EN
  ,
  input  logic       rx_ack,
  output logic       rx_overrun
`endif
);

  generate
    if (longint'(SCL_FREC) * 8 > longint'(CLK_FREC)) begin : g_bad_ratio
      $fatal(1, "spi_slave_interface: CLK_FREC must be at least 8x SCL_FREC");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $fatal(1, "spi_slave_interface: SYNC_STAGES must be 2..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] scl_sync, cs_sync, mosi_sync;
  logic       scl_prev, cs_prev;
  logic       scl_s, cs_s, mosi_s;
  logic       scl_fall, scl_rise, cs_fall, cs_rise;

  logic [7:0] tx_shift, rx_shift;
  logic [2:0] bit_cnt, bit_cnt_tx;
  logic [2:0] tx_idx, rx_idx;
  logic       msb_first;
  logic       done_pending;
  logic       load_tx, byte_done;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      scl_sync  <= '1;
      cs_sync   <= '1;
      mosi_sync <= '0;
      scl_prev  <= 1'b1;
      cs_prev   <= 1'b1;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      scl_prev  <= scl_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign scl_fall = scl_prev & ~scl_s;
  assign scl_rise = ~scl_prev & scl_s;
  assign cs_fall  = cs_prev & ~cs_s;
  assign cs_rise  = ~cs_prev & cs_s;

  assign tx_idx = msb_first ? (3'd7 - bit_cnt_tx) : bit_cnt_tx;
  assign rx_idx = msb_first ? (3'd7 - bit_cnt) : bit_cnt;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_tx   = 1'b0;
    byte_done = 1'b0;
    busy      = 1'b0;
    miso_oe   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) state_nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        load_tx   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        busy    = 1'b1;
        miso_oe = 1'b1;
        if (done_pending) begin
          byte_done = 1'b1;
          load_tx   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Deselect overrides everything, including a byte finishing in the same cycle.
    if (cs_rise) begin
      state_nxt = IDLE;
      load_tx   = 1'b0;
      byte_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tx_shift      <= 8'h00;
      rx_shift      <= 8'h00;
      byte_received <= 8'h00;
      rx_valid      <= 1'b0;
      tx_latched    <= 1'b0;
      miso          <= 1'b0;
      msb_first     <= 1'b1;
      bit_cnt       <= 3'd0;
      bit_cnt_tx    <= 3'd0;
      done_pending  <= 1'b0;
    end else begin
      rx_valid   <= byte_done;
      tx_latched <= load_tx;
      if (load_tx) tx_shift <= byte_2_send;
      if (byte_done) byte_received <= rx_shift;
      if (state == LOAD && !cs_rise) msb_first <= msb_lsb;

      if (state == SHIFT && !cs_rise) begin
        if (done_pending) begin
          bit_cnt      <= 3'd0;
          bit_cnt_tx   <= 3'd0;
          done_pending <= 1'b0;
        end else if (scl_fall) begin
          miso <= tx_shift[tx_idx];
          if (bit_cnt_tx != 3'd7) bit_cnt_tx <= bit_cnt_tx + 3'd1;
        end else if (scl_rise) begin
          rx_shift[rx_idx] <= mosi_s;
          // The eighth bit parks the counter; the byte-complete path wraps it.
          if (bit_cnt == 3'd7) done_pending <= 1'b1;
          else                 bit_cnt      <= bit_cnt + 3'd1;
        end
      end else begin
        miso         <= 1'b0;
        bit_cnt      <= 3'd0;
        bit_cnt_tx   <= 3'd0;
        done_pending <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_DET_EN
  logic unacked;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      unacked    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_valid)    unacked <= 1'b1;
      else if (rx_ack) unacked <= 1'b0;
      // An ack coinciding with rx_valid retires the previous byte, not the new one.
      if (cs_fall)                              rx_overrun <= 1'b0;
      else if (rx_valid && unacked && !rx_ack)  rx_overrun <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_interface.sv
// Randomised mode-3 master driving spi_slave_interface, checked against a byte-level queue model.
`default_nettype none

module tb_spi_slave_interface;
  localparam int S    = 2;
  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       arstn;
  logic [7:0] byte_2_send;
  logic       tx_latched;
  logic [7:0] byte_received;
  logic       rx_valid;
  logic       msb_lsb;
  logic       busy;
  logic       scl;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
`ifdef SPI_SLAVE_OVERRUN_DET_EN
  logic       rx_ack;
  logic       rx_overrun;
`endif

  spi_slave_interface #(
    .CLK_FREC(100000000),
    .SCL_FREC(1000000),
    .SYNC_STAGES(S)
  ) dut (
    .clk(clk),
    .arstn(arstn),
    .byte_2_send(byte_2_send),
    .tx_latched(tx_latched),
    .byte_received(byte_received),
    .rx_valid(rx_valid),
    .msb_lsb(msb_lsb),
    .busy(busy),
    .scl(scl),
    .cs(cs),
    .mosi(mosi),
    .miso(miso),
    .miso_oe(miso_oe)
`ifdef SPI_SLAVE_OVERRUN_DET_EN
    ,
    .rx_ack(rx_ack),
    .rx_overrun(rx_overrun)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         txl_cnt = 0;
  int         rxv_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_rx;
  logic [7:0] tx_b[0:7];
  logic [7:0] rx_b[0:7];
  logic [7:0] got_b[0:7];
  logic [7:0] seq0;
  logic       ovr[0:7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison against the byte-level model.
  initial begin : compare
    logic prev_cs;
    int   age;
    prev_cs  = 1'b1;
    age      = 0;
    model_rx = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (!arstn) begin
        exp_q.delete();
        model_rx = 8'h00;
        age      = 0;
        check("reset_outs", {19'd0, rx_valid, tx_latched, busy, miso, miso_oe, byte_received}, 32'd0);
      end else begin
        if (cs !== prev_cs) age = 0;
        else if (age < 1000) age++;
        prev_cs = cs;
        if (tx_latched) txl_cnt++;
        if (rx_valid) begin
          rxv_cnt++;
          if (exp_q.size() == 0) check("rx_unexpected", {31'd0, rx_valid}, 32'd0);
          else model_rx = exp_q.pop_front();
        end
        check("byte_received", {24'd0, byte_received}, {24'd0, model_rx});
        if (age > S + 4) begin
          check("busy", {31'd0, busy}, {31'd0, ~cs});
          check("miso_oe", {31'd0, miso_oe}, {31'd0, ~cs});
          if (cs) check("miso_idle", {31'd0, miso}, 32'd0);
        end
      end
    end
  end

  // Mode-3 master frame of n bytes; abort_bits>0 drops CS after that many rises of the last byte.
  task automatic frame(input logic msb, input int n, input int abort_bits);
    int lat;
    int idx;
    msb_lsb     = msb;
    byte_2_send = tx_b[0];
    @(negedge clk);
    cs  = 1'b0;
    lat = 0;
    for (int c = 1; c <= 4 * S + 10; c++) begin
      @(negedge clk);
      if (tx_latched) begin
        lat = c;
        break;
      end
    end
    check("cs_tx_latch", {31'd0, (lat > 0 && lat <= S + 3)}, 32'd1);
    check("pre_fall_miso", {31'd0, miso}, 32'd0);
    byte_2_send = tx_b[1];
    repeat (HALF - lat) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        idx  = msb ? 7 - i : i;
        scl  = 1'b0;
        mosi = rx_b[k][idx];
        repeat (HALF) @(negedge clk);
        got_b[k][idx] = miso;
        if (k == 0) seq0 = {seq0[6:0], miso};
        scl = 1'b1;
        lat = 0;
        if (i == 7) begin
          exp_q.push_back(rx_b[k]);
          for (int c = 1; c <= 4 * S + 10; c++) begin
            @(negedge clk);
            if (rx_valid) begin
              lat = c;
              break;
            end
          end
          check("rx_latency", lat, S + 2);
          check("rx_byte", {24'd0, byte_received}, {24'd0, rx_b[k]});
          check("tx_latch_end", {31'd0, tx_latched}, 32'd1);
          byte_2_send = tx_b[k + 2];
`ifdef SPI_SLAVE_OVERRUN_DET_EN
          @(negedge clk);
          lat++;
          ovr[k] = rx_overrun;
`endif
        end
        repeat (HALF - lat) @(negedge clk);
        if (k == n - 1 && i + 1 == abort_bits) begin
          cs = 1'b1;
          repeat (S + 2) @(negedge clk);
          check("abort_miso_oe", {31'd0, miso_oe}, 32'd0);
          check("abort_miso", {31'd0, miso}, 32'd0);
          repeat (20) @(negedge clk);
          return;
        end
      end
      check("miso_byte", {24'd0, got_b[k]}, {24'd0, tx_b[k]});
    end
    cs = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int c0;
    int n;
    int ab;
    logic m;

    arstn       = 1'b0;
    cs          = 1'b1;
    scl         = 1'b1;
    mosi        = 1'b0;
    byte_2_send = 8'h00;
    msb_lsb     = 1'b1;
`ifdef SPI_SLAVE_OVERRUN_DET_EN
    rx_ack      = 1'b0;
`endif
    for (int j = 0; j < 8; j++) begin
      tx_b[j] = 8'h00;
      rx_b[j] = 8'h00;
    end
    repeat (5) @(negedge clk);
    #1;
    check("init_byte_received", {24'd0, byte_received}, 32'd0);
    check("init_flags", {27'd0, rx_valid, tx_latched, busy, miso, miso_oe}, 32'd0);
    @(negedge clk);
    arstn = 1'b1;
    repeat (10) @(negedge clk);

    // One byte MSB-first.
    tx_b[0] = 8'hA5; tx_b[1] = 8'h00; rx_b[0] = 8'h3C;
    c0 = txl_cnt;
    frame(1'b1, 1, 0);
    check("t1_miso_seq", {24'd0, seq0}, 32'h0000_00A5);
    check("t1_rx", {24'd0, byte_received}, 32'h0000_003C);
    check("t1_txl_count", txl_cnt - c0, 2);

    // One byte LSB-first.
    tx_b[0] = 8'h80; rx_b[0] = 8'h01;
    frame(1'b0, 1, 0);
    check("t2_rx", {24'd0, byte_received}, 32'h0000_0001);
    check("t2_first_bit", {31'd0, seq0[7]}, 32'd0);
    check("t2_last_bit", {31'd0, seq0[0]}, 32'd1);

    // Three-byte burst.
    tx_b[0] = 8'h11; tx_b[1] = 8'h22; tx_b[2] = 8'h33; tx_b[3] = 8'h00; tx_b[4] = 8'h00;
    rx_b[0] = 8'hDE; rx_b[1] = 8'hAD; rx_b[2] = 8'hBE;
    c0 = rxv_cnt;
    frame(1'b1, 3, 0);
    check("t3_rx_count", rxv_cnt - c0, 3);
    check("t3_miso_b1", {24'd0, got_b[1]}, 32'h0000_0022);
    check("t3_miso_b2", {24'd0, got_b[2]}, 32'h0000_0033);
    check("t3_rx_last", {24'd0, byte_received}, 32'h0000_00BE);

    // Partial byte then full byte.
    rx_b[0] = 8'hC3;
    c0 = rxv_cnt;
    frame(1'b1, 1, 4);
    check("t4_partial_no_rx", rxv_cnt - c0, 0);
    check("t4_held", {24'd0, byte_received}, 32'h0000_00BE);
    rx_b[0] = 8'h55;
    frame(1'b1, 1, 0);
    check("t4_rx", {24'd0, byte_received}, 32'h0000_0055);

    // Reset in the middle of a byte.
    msb_lsb     = 1'b1;
    byte_2_send = 8'h9A;
    @(negedge clk);
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      scl  = 1'b0;
      mosi = 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
      scl = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    scl = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    check("t5_busy_before", {31'd0, busy}, 32'd1);
    arstn = 1'b0;
    #1;
    check("t5_rst_byte", {24'd0, byte_received}, 32'd0);
    check("t5_rst_flags", {27'd0, rx_valid, tx_latched, busy, miso, miso_oe}, 32'd0);
    cs  = 1'b1;
    scl = 1'b1;
    repeat (5) @(negedge clk);
    arstn = 1'b1;
    repeat (10) @(negedge clk);
    tx_b[0] = 8'h3E; rx_b[0] = 8'hF0;
    frame(1'b1, 1, 0);
    check("t5_rx", {24'd0, byte_received}, 32'h0000_00F0);

`ifdef SPI_SLAVE_OVERRUN_DET_EN
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    tx_b[0] = 8'h5A; tx_b[1] = 8'hC6; rx_b[0] = 8'h12; rx_b[1] = 8'h34;
    frame(1'b1, 2, 0);
    check("ovr_first", {31'd0, ovr[0]}, 32'd0);
    check("ovr_second", {31'd0, ovr[1]}, 32'd1);
    check("ovr_sticky", {31'd0, rx_overrun}, 32'd1);
    @(negedge clk);
    cs = 1'b0;
    repeat (S + 5) @(negedge clk);
    check("ovr_clear", {31'd0, rx_overrun}, 32'd0);
    cs = 1'b1;
    repeat (30) @(negedge clk);
`endif

    // Randomised frames.
    repeat (12) begin
      m = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      for (int j = 0; j < 8; j++) begin
        tx_b[j] = 8'($urandom);
        rx_b[j] = 8'($urandom);
      end
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      c0 = rxv_cnt;
      frame(m, n, ab);
      check("rand_rx_count", rxv_cnt - c0, (ab != 0) ? n - 1 : n);
      repeat ($urandom_range(5, 40)) @(negedge clk);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
